// File: rtl/regs_port_ctrl.sv
// rtl/regs_port_ctrl.sv - operand-fetch sequencer for a single-read-port register memory
//
// After reset, walks every register address and writes UNITY to it. It then serves
// two-operand fetch requests by time-multiplexing the memory's one registered read port.
//
// Optional feature macro: REGS_FWD_EN (write-to-read forwarding around read-old-data).
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   req_valid/req_ready        operand fetch handshake (rs_addr/rt_addr sampled on accept)
//   op_valid, rs_data, rt_data one-cycle result pulse with registered operands
//   wr_en, wr_addr, wr_data    register write request (dropped until init_done)
//   init_done                  high once the init walk has completed
//   mem_rd_addr, mem_wr_addr,
//   mem_d, mem_we              to the register memory
//   mem_q                      from the register memory (1-cycle registered read)
module regs_port_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int UNITY  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              op_valid,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CAP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] rs_l;
  logic [ADDR_W-1:0] rt_l;
  logic              accept;
  logic              init_last;
  logic [DATA_W-1:0] operand;

  assign accept    = req_valid & req_ready;
  assign init_last = (init_cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    mem_rd_addr = rs_addr;
    mem_we      = wr_en & init_done;
    mem_wr_addr = wr_addr;
    mem_d       = wr_data;
    case (state)
      S_INIT: begin
        mem_we      = 1'b1;
        mem_wr_addr = init_cnt;
        mem_d       = DATA_W'(UNITY);
        if (init_last) begin
          state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        req_ready = init_done;
        if (accept) begin
          state_nxt = S_RD_A;
        end
      end
      S_RD_A: begin
        mem_rd_addr = rs_l;
        state_nxt   = S_RD_B;
      end
      S_RD_B: begin
        mem_rd_addr = rt_l;
        state_nxt   = S_CAP;
      end
      S_CAP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

`ifdef REGS_FWD_EN
  // One forwarding slot is enough: the rs snoop taken in RD_A is consumed at the
  // RD_B edge, the same edge at which the rt snoop for RD_B is taken.
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else if (state == S_RD_A || state == S_RD_B) begin
      fwd_hit  <= wr_en & init_done & (wr_addr == mem_rd_addr);
      fwd_data <= wr_data;
    end else begin
      fwd_hit  <= 1'b0;
    end
  end

  assign operand = fwd_hit ? fwd_data : mem_q;
`else
  // Without forwarding a write in the address-present cycle returns the old value.
  assign operand = mem_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
      op_valid  <= 1'b0;
      rs_data   <= '0;
      rt_data   <= '0;
      rs_l      <= '0;
      rt_l      <= '0;
    end else begin
      op_valid <= (state == S_CAP);
      if (state == S_INIT) begin
        init_cnt <= init_cnt + ADDR_W'(1);
        if (init_last) begin
          init_done <= 1'b1;
        end
      end
      if (accept) begin
        rs_l <= rs_addr;
        rt_l <= rt_addr;
      end
      // mem_q carries the rs read during RD_B and the rt read during CAP.
      if (state == S_RD_B) begin
        rs_data <= operand;
      end
      if (state == S_CAP) begin
        rt_data <= operand;
      end
    end
  end

endmodule

// File: tb/tb_regs_port_ctrl.sv
// tb/tb_regs_port_ctrl.sv - scoreboard bench for regs_port_ctrl against a register-file model
module tb_regs_port_ctrl;
  localparam int AW = 3;
  localparam int DW = 8;
`ifdef REGS_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] rs_addr = '0;
  logic [AW-1:0] rt_addr = '0;
  logic          op_valid;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          init_done;
  logic [AW-1:0] mem_rd_addr;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic [DW-1:0] mem_q;

  always #5 clk = ~clk;

  regs_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .UNITY(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .op_valid(op_valid), .rs_data(rs_data), .rt_data(rt_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(init_done),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q)
  );

  // Register memory: registered read, returns old data on a same-address write.
  logic [DW-1:0] mem_arr [8];
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_wr_addr] <= mem_d;
    mem_q <= mem_arr[mem_rd_addr];
  end

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Reference model: architectural register contents plus the fetch in progress.
  logic [DW-1:0] ref_regs [8];
  int            m_cnt = 0;
  bit            m_done = 1'b0;
  int            m_age = 0;   // cycles since acceptance; 0 = no fetch in flight
  logic [AW-1:0] m_rs, m_rt;
  logic [DW-1:0] e_rs, e_rt;
  bit            m_opv = 1'b0;
  logic [15:0]   sbq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_write();
    if (wr_en) ref_regs[wr_addr] = wr_data;
  endtask

  // Evaluated right after each posedge with the inputs of the cycle that just ended.
  task automatic model_step();
    m_opv = 1'b0;
    if (reset) begin
      m_cnt = 0; m_done = 1'b0; m_age = 0;
      return;
    end
    if (!m_done) begin
      m_cnt++;
      if (m_cnt == 8) begin
        m_done = 1'b1;
        foreach (ref_regs[i]) ref_regs[i] = 8'h10;
      end
      return;
    end
    case (m_age)
      0: begin
        apply_write();                       // acceptance-cycle write is visible
        if (req_valid) begin
          m_rs = rs_addr; m_rt = rt_addr;
          e_rs = ref_regs[m_rs];
          m_age = 1;
        end
      end
      1: begin
        if (FWD && wr_en && wr_addr == m_rs) e_rs = wr_data;
        apply_write();
        e_rt = ref_regs[m_rt];               // rt sees writes up to this cycle
        m_age = 2;
      end
      2: begin
        if (FWD && wr_en && wr_addr == m_rt) e_rt = wr_data;
        apply_write();
        m_age = 3;
      end
      default: begin
        apply_write();
        sbq.push_back({e_rs, e_rt});
        m_opv = 1'b1;
        m_age = 0;
      end
    endcase
  endtask

  task automatic cycle(input bit rst, input bit rv, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    reset = rst; req_valid = rv; rs_addr = ra; rt_addr = rb;
    wr_en = we; wr_addr = wa; wr_data = wd;
    #1;
    if (started) begin
      chk("init_done", init_done, m_done);
      chk("req_ready", req_ready, m_done && m_age == 0);
      if (!m_done) begin
        chk("init_we", mem_we, 1);
        chk("init_waddr", mem_wr_addr, m_cnt[AW-1:0]);
        chk("init_d", mem_d, 8'h10);
      end else begin
        chk("pass_we", mem_we, we);
        if (we) begin
          chk("pass_waddr", mem_wr_addr, wa);
          chk("pass_d", mem_d, wd);
        end
      end
    end
    @(posedge clk);
    model_step();
    started = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  logic [15:0] exp_op;
  always @(negedge clk) begin
    if (started) begin
      chk("op_valid", op_valid, m_opv);
      if (op_valid) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 0, 1);
        end else begin
          exp_op = sbq.pop_front();
          chk("rs_data", rs_data, exp_op[15:8]);
          chk("rt_data", rt_data, exp_op[7:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0, 0);
    // Init walk; write to r1 in cycle 3 must be dropped.
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, i == 3, 3'd1, 8'h99);
    chk("init_done_after_walk", init_done, 1);

    cycle(0, 0, 0, 0, 1, 3'd2, 8'h33);
    cycle(0, 0, 0, 0, 1, 3'd5, 8'h5A);
    cycle(0, 1, 3'd2, 3'd5, 0, 0, 0);
    idle(3);
    chk("dir_op_valid", op_valid, 1);
    chk("dir_rs_2", rs_data, 8'h33);
    chk("dir_rt_5", rt_data, 8'h5A);

    cycle(0, 1, 3'd3, 3'd4, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 3'd3, 8'h77);   // RD_A
    cycle(0, 0, 0, 0, 1, 3'd4, 8'h21);   // RD_B
    idle(1);
    chk("fwd_rs_3", rs_data, FWD ? 8'h77 : 8'h10);
    chk("fwd_rt_4", rt_data, FWD ? 8'h21 : 8'h10);

    cycle(0, 1, 3'd1, 3'd1, 0, 0, 0);
    idle(3);
    chk("dropped_rs_1", rs_data, 8'h10);
    chk("dropped_rt_1", rt_data, 8'h10);

    // Reset in RD_B of a fetch.
    cycle(0, 1, 3'd6, 3'd7, 0, 0, 0);
    idle(1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      cycle(0, $urandom_range(0, 1), 3'($urandom), 3'($urandom), $urandom_range(0, 1), 3'($urandom), 8'($urandom));
    chk("reinit_done", init_done, 1);

    // Held request with alternating addresses.
    for (int i = 0; i < 24; i++)
      cycle(0, 1, i[2] ? 3'd1 : 3'd6, i[2] ? 3'd6 : 3'd1, $urandom_range(0, 1), 3'($urandom), 8'($urandom));

    // Fully random traffic with occasional reset.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 1), 3'($urandom), 3'($urandom),
            $urandom_range(0, 1), 3'($urandom), 8'($urandom));

    idle(14);
    chk("scoreboard_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
